// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared definitions for the UART transmit FIFO controller: the launch FSM
// encoding and a constant-evaluable ceiling log2 used for pointer widths.
package uart_tx_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } tx_state_e;

  // Smallest r such that 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO. It has a circular buffer and registered
// occupancy flags. A write into a full FIFO is still taken when a pop
// happens in the same cycle, because that pop frees the slot being written.
module uart_sync_fifo
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   wr_accept,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          do_wr;
  logic          do_rd;

  assign do_rd     = rd_en && !empty_q;
  assign do_wr     = wr_en && (!full_q || do_rd);
  assign wr_accept = do_wr;
  assign rd_data   = mem[rd_ptr];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

  // Storage array; contents survive reset because only the pointers matter.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count_q + (AW + 1)'(1);
      2'b01:   count_nxt = count_q - (AW + 1)'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  // The flags are registered from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == FULL_COUNT);
      empty_q <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit front end. It queues bytes in a FIFO and hands them one at a
// time to a byte transmitter using a start/finish handshake. A transfer is
// abandoned if the transmitter does not finish in time. Dropped writes and
// timeouts are recorded in sticky error flags.
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   WR_EN_I,
  input  logic [7:0]             WR_DATA_I,
  output logic                   FULL_O,
  output logic                   EMPTY_O,
  output logic [clog2(DEPTH):0]  COUNT_O,
  output logic                   OVF_O,
  output logic                   TMO_O,
  input  logic                   CLR_ERR_I,
  output logic                   TX_START_O,
  output logic [7:0]             TX_DATA_O,
  input  logic                   TX_FINISH_I,
  input  logic                   TX_BUSY_I
);

  localparam int TW = clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  tx_state_e     state_q;
  tx_state_e     state_nxt;
  logic [TW-1:0] timer_q;
  logic [7:0]    tx_data_q;
  logic [7:0]    fifo_rd_data;
  logic          fifo_empty;
  logic          wr_accept;
  logic          pop;
  logic          timer_clr;
  logic          timer_inc;
  logic          tmo_set;
  logic          ovf_q;
  logic          tmo_q;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK_I),
    .rst       (RST_I),
    .wr_en     (WR_EN_I),
    .wr_data   (WR_DATA_I),
    .rd_en     (pop),
    .rd_data   (fifo_rd_data),
    .wr_accept (wr_accept),
    .count     (COUNT_O),
    .full      (FULL_O),
    .empty     (fifo_empty)
  );

  assign EMPTY_O    = fifo_empty;
  assign TX_START_O = (state_q == LAUNCH);
  assign TX_DATA_O  = tx_data_q;
  assign OVF_O      = ovf_q;
  assign TMO_O      = tmo_q;

  // Launch FSM next state. A finish in the same cycle as the last allowed
  // wait cycle counts as success, so the timeout is checked only after it.
  always_comb begin
    state_nxt = state_q;
    pop       = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    tmo_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !TX_BUSY_I) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_clr = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (TX_FINISH_I) begin
          state_nxt = IDLE;
        end else if (timer_q == TMO_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, timeout counter and output byte. The byte is captured at the
  // moment of the pop and held until the next pop, so it is never re-sent.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q <= state_nxt;
      if (timer_clr) begin
        timer_q <= '0;
      end else if (timer_inc) begin
        timer_q <= timer_q + TW'(1);
      end
      if (pop) begin
        tx_data_q <= fifo_rd_data;
      end
    end
  end

  // Sticky error flags. A clear wins over a set in the same cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else if (CLR_ERR_I) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (WR_EN_I && !wr_accept) begin
        ovf_q <= 1'b1;
      end
      if (tmo_set) begin
        tmo_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed testbench for uart_tx_fifo_ctrl with DEPTH=16 and a short
// timeout. A small transmitter model answers launches with a finish pulse
// when enabled. A monitor records every launched byte.
module tb_uart_tx_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int TMO   = 10;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic       WR_EN_I;
  logic [7:0] WR_DATA_I;
  logic       FULL_O;
  logic       EMPTY_O;
  logic [4:0] COUNT_O;
  logic       OVF_O;
  logic       TMO_O;
  logic       CLR_ERR_I;
  logic       TX_START_O;
  logic [7:0] TX_DATA_O;
  logic       TX_FINISH_I;
  logic       TX_BUSY_I;

  int         checks = 0;
  int         errors = 0;
  bit         auto_finish = 1'b0;
  logic [7:0] sent_q[$];

  uart_tx_fifo_ctrl #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .WR_EN_I     (WR_EN_I),
    .WR_DATA_I   (WR_DATA_I),
    .FULL_O      (FULL_O),
    .EMPTY_O     (EMPTY_O),
    .COUNT_O     (COUNT_O),
    .OVF_O       (OVF_O),
    .TMO_O       (TMO_O),
    .CLR_ERR_I   (CLR_ERR_I),
    .TX_START_O  (TX_START_O),
    .TX_DATA_O   (TX_DATA_O),
    .TX_FINISH_I (TX_FINISH_I),
    .TX_BUSY_I   (TX_BUSY_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Record every launched byte, sampled mid-cycle.
  always @(negedge CLK_I) begin
    if (RST_I === 1'b0 && TX_START_O === 1'b1) sent_q.push_back(TX_DATA_O);
  end

  // Transmitter model: finish two cycles after a launch when enabled.
  initial begin
    TX_FINISH_I = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (auto_finish && TX_START_O === 1'b1 && RST_I === 1'b0) begin
        @(negedge CLK_I);
        @(negedge CLK_I);
        TX_FINISH_I = 1'b1;
        @(negedge CLK_I);
        TX_FINISH_I = 1'b0;
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    RST_I = 1'b1; WR_EN_I = 1'b0; WR_DATA_I = 8'h00; CLR_ERR_I = 1'b0; TX_BUSY_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    checks++; if (EMPTY_O !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b expected 1", EMPTY_O); end
    checks++; if (FULL_O !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b expected 0", FULL_O); end
    checks++; if (COUNT_O !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", COUNT_O); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", OVF_O); end
    checks++; if (TMO_O !== 1'b0) begin errors++; $display("[TB] FAIL reset_tmo got %b expected 0", TMO_O); end
    checks++; if (TX_START_O !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b expected 0", TX_START_O); end
    checks++; if (TX_DATA_O !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h expected 00", TX_DATA_O); end
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    checks++; if (TX_START_O !== 1'b0 || EMPTY_O !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle got start=%b empty=%b expected start=0 empty=1", TX_START_O, EMPTY_O); end
  endtask

  task automatic test_latency();
    auto_finish = 1'b1;
    TX_BUSY_I = 1'b0;
    @(negedge CLK_I); WR_EN_I = 1'b1; WR_DATA_I = 8'hA5;
    @(negedge CLK_I); WR_EN_I = 1'b0;
    checks++; if (EMPTY_O !== 1'b0 || COUNT_O !== 5'd1) begin errors++; $display("[TB] FAIL lat_queued got empty=%b count=%0d expected empty=0 count=1", EMPTY_O, COUNT_O); end
    checks++; if (TX_START_O !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_start got %b expected 0", TX_START_O); end
    @(negedge CLK_I);
    checks++; if (TX_START_O !== 1'b1) begin errors++; $display("[TB] FAIL lat_start got %b expected 1", TX_START_O); end
    checks++; if (TX_DATA_O !== 8'hA5) begin errors++; $display("[TB] FAIL lat_data got %h expected a5", TX_DATA_O); end
    checks++; if (EMPTY_O !== 1'b1 || COUNT_O !== 5'd0) begin errors++; $display("[TB] FAIL lat_popped got empty=%b count=%0d expected empty=1 count=0", EMPTY_O, COUNT_O); end
    @(negedge CLK_I);
    checks++; if (TX_START_O !== 1'b0 || TX_DATA_O !== 8'hA5) begin errors++; $display("[TB] FAIL lat_hold got start=%b data=%h expected start=0 data=a5", TX_START_O, TX_DATA_O); end
    repeat (6) @(negedge CLK_I);
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin errors++; $display("[TB] FAIL lat_sent got size=%0d expected size=1 byte a5", sent_q.size()); end
    sent_q.delete();
  endtask

  task automatic test_overflow();
    TX_BUSY_I = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK_I);
      WR_EN_I = 1'b1; WR_DATA_I = 8'(i); CLR_ERR_I = (i == 16);
    end
    @(negedge CLK_I); WR_EN_I = 1'b0; CLR_ERR_I = 1'b0;
    checks++; if (COUNT_O !== 5'd16 || FULL_O !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got count=%0d full=%b expected count=16 full=1", COUNT_O, FULL_O); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clr_priority got %b expected 0", OVF_O); end
    WR_EN_I = 1'b1; WR_DATA_I = 8'h11;
    @(negedge CLK_I); WR_EN_I = 1'b0;
    checks++; if (OVF_O !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b expected 1", OVF_O); end
    checks++; if (COUNT_O !== 5'd16 || FULL_O !== 1'b1 || EMPTY_O !== 1'b0) begin errors++; $display("[TB] FAIL ovf_still_full got count=%0d full=%b empty=%b expected 16 1 0", COUNT_O, FULL_O, EMPTY_O); end
    checks++; if (sent_q.size() != 0) begin errors++; $display("[TB] FAIL ovf_busy_hold got sent=%0d expected 0", sent_q.size()); end
  endtask

  task automatic test_full_write_pop();
    logic [7:0] exp;
    CLR_ERR_I = 1'b1;
    @(negedge CLK_I); CLR_ERR_I = 1'b0;
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("[TB] FAIL fwp_clear got %b expected 0", OVF_O); end
    TX_BUSY_I = 1'b0; WR_EN_I = 1'b1; WR_DATA_I = 8'h55;
    @(negedge CLK_I); WR_EN_I = 1'b0;
    checks++; if (COUNT_O !== 5'd16 || FULL_O !== 1'b1) begin errors++; $display("[TB] FAIL fwp_count got count=%0d full=%b expected 16 1", COUNT_O, FULL_O); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("[TB] FAIL fwp_ovf got %b expected 0", OVF_O); end
    checks++; if (TX_START_O !== 1'b1 || TX_DATA_O !== 8'h00) begin errors++; $display("[TB] FAIL fwp_launch got start=%b data=%h expected 1 00", TX_START_O, TX_DATA_O); end
    for (int c = 0; c < 400 && sent_q.size() < 17; c++) @(negedge CLK_I);
    repeat (20) @(negedge CLK_I);
    checks++; if (sent_q.size() != 17) begin errors++; $display("[TB] FAIL fwp_sent_count got %0d expected 17", sent_q.size()); end
    for (int i = 0; i < 17; i++) begin
      exp = (i < 16) ? 8'(i) : 8'h55;
      checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp) begin
        errors++; $display("[TB] FAIL fwp_order[%0d] got %h expected %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp);
      end
    end
    checks++; if (EMPTY_O !== 1'b1 || OVF_O !== 1'b0) begin errors++; $display("[TB] FAIL fwp_drained got empty=%b ovf=%b expected 1 0", EMPTY_O, OVF_O); end
    sent_q.delete();
  endtask

  task automatic test_timeout();
    auto_finish = 1'b0;
    TX_BUSY_I = 1'b0;
    checks++; if (TMO_O !== 1'b0) begin errors++; $display("[TB] FAIL tmo_initial got %b expected 0", TMO_O); end
    @(negedge CLK_I); WR_EN_I = 1'b1; WR_DATA_I = 8'h31;
    @(negedge CLK_I); WR_DATA_I = 8'h32;
    @(negedge CLK_I); WR_EN_I = 1'b0;
    checks++; if (TX_START_O !== 1'b1 || TX_DATA_O !== 8'h31) begin errors++; $display("[TB] FAIL tmo_launch1 got start=%b data=%h expected 1 31", TX_START_O, TX_DATA_O); end
    for (int w = 1; w <= 9; w++) begin
      @(negedge CLK_I);
      checks++; if (TX_START_O !== 1'b0 || TMO_O !== 1'b0) begin errors++; $display("[TB] FAIL tmo_wait%0d got start=%b tmo=%b expected 0 0", w, TX_START_O, TMO_O); end
    end
    repeat (2) @(negedge CLK_I);
    checks++; if (TMO_O !== 1'b1) begin errors++; $display("[TB] FAIL tmo_set got %b expected 1", TMO_O); end
    for (int c = 0; c < 4 && TX_START_O !== 1'b1; c++) @(negedge CLK_I);
    checks++; if (TX_START_O !== 1'b1 || TX_DATA_O !== 8'h32) begin errors++; $display("[TB] FAIL tmo_next_launch got start=%b data=%h expected 1 32", TX_START_O, TX_DATA_O); end
    repeat (16) @(negedge CLK_I);
    checks++; if (sent_q.size() != 2 || sent_q[0] !== 8'h31 || sent_q[1] !== 8'h32) begin errors++; $display("[TB] FAIL tmo_no_resend got size=%0d expected 2 bytes 31 32", sent_q.size()); end
    checks++; if (TMO_O !== 1'b1 || EMPTY_O !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky got tmo=%b empty=%b expected 1 1", TMO_O, EMPTY_O); end
    CLR_ERR_I = 1'b1;
    @(negedge CLK_I); CLR_ERR_I = 1'b0;
    checks++; if (TMO_O !== 1'b0) begin errors++; $display("[TB] FAIL tmo_clear got %b expected 0", TMO_O); end
    sent_q.delete();
  endtask

  task automatic test_reset_mid();
    int n0;
    auto_finish = 1'b0;
    TX_BUSY_I = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK_I); WR_EN_I = 1'b1; WR_DATA_I = 8'hC0 + 8'(i);
    end
    @(negedge CLK_I); WR_EN_I = 1'b0;
    checks++; if (COUNT_O !== 5'd5 || TX_DATA_O !== 8'hC0) begin errors++; $display("[TB] FAIL rst_mid_pre got count=%0d data=%h expected 5 c0", COUNT_O, TX_DATA_O); end
    #1 RST_I = 1'b1;
    #1;
    checks++; if (COUNT_O !== 5'd0 || EMPTY_O !== 1'b1 || FULL_O !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_fifo got count=%0d empty=%b full=%b expected 0 1 0", COUNT_O, EMPTY_O, FULL_O); end
    checks++; if (TX_DATA_O !== 8'h00 || TX_START_O !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tx got data=%h start=%b expected 00 0", TX_DATA_O, TX_START_O); end
    checks++; if (OVF_O !== 1'b0 || TMO_O !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_flags got ovf=%b tmo=%b expected 0 0", OVF_O, TMO_O); end
    @(negedge CLK_I); RST_I = 1'b0;
    n0 = sent_q.size();
    repeat (20) @(negedge CLK_I);
    checks++; if (sent_q.size() != n0 || EMPTY_O !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_quiet got launches=%0d empty=%b expected 0 1", sent_q.size() - n0, EMPTY_O); end
    auto_finish = 1'b1;
    @(negedge CLK_I); WR_EN_I = 1'b1; WR_DATA_I = 8'h77;
    @(negedge CLK_I); WR_EN_I = 1'b0;
    for (int c = 0; c < 4 && TX_START_O !== 1'b1; c++) @(negedge CLK_I);
    checks++; if (TX_START_O !== 1'b1 || TX_DATA_O !== 8'h77) begin errors++; $display("[TB] FAIL rst_mid_resume got start=%b data=%h expected 1 77", TX_START_O, TX_DATA_O); end
    repeat (8) @(negedge CLK_I);
    sent_q.delete();
  endtask

  task automatic test_wrap();
    int         written;
    logic [7:0] exp;
    auto_finish = 1'b1;
    TX_BUSY_I = 1'b0;
    written = 0;
    for (int c = 0; c < 2000 && written < 40; c++) begin
      @(negedge CLK_I);
      if (FULL_O === 1'b0) begin
        WR_EN_I = 1'b1; WR_DATA_I = 8'(written * 37 + 11); written++;
      end else begin
        WR_EN_I = 1'b0;
      end
    end
    @(negedge CLK_I); WR_EN_I = 1'b0;
    checks++; if (written != 40) begin errors++; $display("[TB] FAIL wrap_written got %0d expected 40", written); end
    for (int c = 0; c < 600 && sent_q.size() < 40; c++) @(negedge CLK_I);
    repeat (10) @(negedge CLK_I);
    checks++; if (sent_q.size() != 40) begin errors++; $display("[TB] FAIL wrap_sent_count got %0d expected 40", sent_q.size()); end
    for (int i = 0; i < 40; i++) begin
      exp = 8'(i * 37 + 11);
      checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp) begin
        errors++; $display("[TB] FAIL wrap_order[%0d] got %h expected %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp);
      end
    end
    checks++; if (OVF_O !== 1'b0 || EMPTY_O !== 1'b1 || COUNT_O !== 5'd0) begin errors++; $display("[TB] FAIL wrap_end got ovf=%b empty=%b count=%0d expected 0 1 0", OVF_O, EMPTY_O, COUNT_O); end
  endtask

  // Run the scenarios in sequence and report.
  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_full_write_pop();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
